// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Arbitrates I-fetch and D-load/store requests onto one shared memory port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_err
);

  localparam int TCW = $clog2(TIMEOUT);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           owner_d;
  logic [TCW-1:0] tcnt;
  logic [SCW-1:0] scnt;

  logic grant_i;
  logic grant_d;
  logic done_ok;
  logic done_abort;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // D-side normally wins a tie; the fetch side is forced once it has lost STARVE_LIMIT times.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(i_req && (scnt == STARVE_MAX))) grant_d = 1'b1;
        else if (i_req)                                grant_i = 1'b1;
        if (grant_d || grant_i) state_next = BUSY;
      end
      BUSY: begin
        if (mem_ack) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (tcnt == TO_LAST) begin
          done_abort = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d   <= 1'b0;
      tcnt      <= '0;
      scnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grant_d || grant_i) begin
        owner_d   <= grant_d;
        mem_req   <= 1'b1;
        mem_we    <= grant_d & d_we;
        mem_addr  <= grant_d ? d_addr  : i_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
        tcnt      <= '0;
        if (grant_i)                            scnt <= '0;
        else if (i_req && (scnt != STARVE_MAX)) scnt <= scnt + SCW'(1);
      end
      if (done_ok || done_abort) begin
        mem_req <= 1'b0;
        if (owner_d) begin
          d_ack   <= 1'b1;
          d_rdata <= done_ok ? mem_rdata : '0;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= done_ok ? mem_rdata : '0;
        end
        if (done_abort) bus_err <= 1'b1;
      end else if (state == BUSY) begin
        tcnt <= tcnt + TCW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                        |
// | Directed and randomized checks of mem_port_arbiter against a request model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int TO    = 16;
  localparam int SLIM  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_ack, d_ack, mem_req, mem_we, bus_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int starve_m = 0;
  bit err_m    = 1'b0;
  bit last_obs_d;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state;
    chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},  32'd0);
    chk("rst_mem_addr",  mem_addr,         32'd0);
    chk("rst_mem_wdata", mem_wdata,        32'd0);
    chk("rst_i_ack",     {31'd0, i_ack},   32'd0);
    chk("rst_d_ack",     {31'd0, d_ack},   32'd0);
    chk("rst_i_rdata",   i_rdata,          32'd0);
    chk("rst_d_rdata",   d_rdata,          32'd0);
    chk("rst_bus_err",   {31'd0, bus_err}, 32'd0);
  endtask

  // Arbitration rule: D wins unless I is pending and has already lost SLIM times in a row.
  function automatic bit pick_d(bit ip, bit dp, int s);
    return dp && !(ip && s == SLIM);
  endfunction

  // Called in IDLE with at least one request driven; runs one complete access.
  task automatic access(input int wait_n, input logic [31:0] rd);
    bit          win_d, ewe, tmo;
    logic [31:0] ea, ew, erd;
    int          nb;
    win_d = pick_d(i_req, d_req, starve_m);
    if (win_d) begin
      if (i_req) starve_m = (starve_m < SLIM) ? starve_m + 1 : SLIM;
    end else begin
      starve_m = 0;
    end
    ea  = win_d ? d_addr : i_addr;
    ewe = win_d & d_we;
    ew  = d_wdata;
    tmo = (wait_n >= TO);
    nb  = tmo ? TO : wait_n + 1;
    tick;
    last_obs_d = d_req && (mem_addr === d_addr);
    for (int c = 0; c < nb; c++) begin
      chk("busy_mem_req", {31'd0, mem_req}, 32'd1);
      chk("busy_mem_addr", mem_addr, ea);
      chk("busy_mem_we", {31'd0, mem_we}, {31'd0, ewe});
      if (ewe) chk("busy_mem_wdata", mem_wdata, ew);
      chk("busy_acks", {30'd0, i_ack, d_ack}, 32'd0);
      if (!tmo && c == nb - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      tick;
    end
    if (tmo) err_m = 1'b1;
    erd = tmo ? 32'd0 : rd;
    chk("resp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("resp_acks", {30'd0, i_ack, d_ack}, {30'd0, !win_d, win_d});
    chk("resp_rdata", win_d ? d_rdata : i_rdata, erd);
    chk("resp_bus_err", {31'd0, bus_err}, {31'd0, err_m});
    if (win_d) d_req = 1'b0;
    else       i_req = 1'b0;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    tick;
    chk("idle_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    logic [9:0] order;
    int         wn;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick; tick;
    chk_reset_state();
    rst = 1'b0;

    // Single fetch with a zero-wait memory.
    i_req = 1'b1; i_addr = 32'h0000_0040;
    access(0, 32'h0051_0093);

    // Simultaneous requests: D first, then I.
    i_req = 1'b1; i_addr = 32'h0000_0044;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
    access(0, 32'h1111_2222);
    chk("tie_first_d", {31'd0, last_obs_d}, 32'd1);
    access(0, 32'h3333_4444);
    chk("tie_second_i", {31'd0, last_obs_d}, 32'd0);

    // Both sides continuously requesting: fetch forced after SLIM data wins.
    order = '0;
    i_req = 1'b1; i_addr = 32'h1000_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0000;
    for (int n = 0; n < 10; n++) begin
      access(0, $urandom);
      order = {order[8:0], last_obs_d};
      if (!i_req) begin i_req = 1'b1; i_addr = i_addr + 32'd4; end
      if (!d_req) begin d_req = 1'b1; d_addr = d_addr + 32'd4; end
    end
    chk("starve_order", {22'd0, order}, {22'd0, 10'b1111011110});
    access(0, $urandom);
    if (i_req) access(0, $urandom);
    if (d_req) access(0, $urandom);

    // Store with a three-cycle BUSY phase.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'hDEAD_BEEF;
    access(2, 32'h5555_AAAA);

    // Timeout on a fetch, then a successful access with the sticky error.
    i_req = 1'b1; i_addr = 32'h0000_0080;
    access(TO, 32'h7777_7777);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
    access(1, 32'h0BAD_F00D);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req  = 1'b1;
        i_addr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
        d_wdata = $urandom;
      end
      if (!i_req && !d_req) begin
        mem_ack = 1'($urandom_range(0, 1));
        tick;
        chk("rand_idle_req", {31'd0, mem_req}, 32'd0);
        chk("rand_idle_acks", {30'd0, i_ack, d_ack}, 32'd0);
      end else begin
        wn = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3));
        access(wn, $urandom);
      end
    end
    while (i_req || d_req) access(0, $urandom);

    // Reset in the middle of an outstanding store; the store is then re-issued.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hCAFE_F00D;
    mem_ack = 1'b0;
    tick;
    chk("pre_rst_busy", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    tick;
    chk_reset_state();
    rst = 1'b0;
    err_m = 1'b0;
    starve_m = 0;
    access(1, 32'h0123_4567);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
